// File: rtl/mdu_57_pkg.sv
// mdu_57_pkg -- shared definitions for the mdu_57 multiply/divide unit.
//   op encodings, FSM state enum, divider cycle counts and a small
//   conditional absolute-value helper used by the divider setup step.
package mdu_57_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int DIV_ITERS  = 32;
  localparam int DIV_CYCLES = 34;  // setup + DIV_ITERS + sign fix

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_SETUP,
    DIV_ITER,
    DIV_FIX
  } state_t;

  // Magnitude of v when it is a signed operand, v itself otherwise.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_57_div.sv
// mdu_57_div -- iterative restoring divider core.
//   start      : latch dividend/divisor/is_signed (only honoured when idle)
//   abort      : return to idle, result discarded
//   iter_last  : high during the final restoring iteration
//   done       : high during the sign-fix cycle; quotient/remainder valid
//   div_zero   : divisor was zero (result must not be committed)
// Sequence: setup (magnitudes) -> DIV_ITERS iterations -> sign fix.
module mdu_57_div
  import mdu_57_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        iter_last,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  state_t      phase;
  logic [31:0] a_q, b_q, dvs, quo, rem;
  logic        sgn, neg_q, neg_r, dz;
  logic [4:0]  cnt;

  // One restoring step: shift next dividend bit into the partial remainder
  // and subtract the divisor; a clear borrow bit means the subtract stands.
  logic [32:0] rem_sh, diff;
  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, dvs};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      dvs   <= '0;
      quo   <= '0;
      rem   <= '0;
      sgn   <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      cnt   <= '0;
    end else if (abort) begin
      phase <= IDLE;
    end else begin
      case (phase)
        IDLE: if (start) begin
          a_q   <= dividend;
          b_q   <= divisor;
          sgn   <= is_signed;
          phase <= DIV_SETUP;
        end
        DIV_SETUP: begin
          quo   <= abs_if(a_q, sgn);
          dvs   <= abs_if(b_q, sgn);
          rem   <= '0;
          neg_q <= sgn && (a_q[31] ^ b_q[31]);
          neg_r <= sgn && a_q[31];
          dz    <= (b_q == '0);
          cnt   <= '0;
          phase <= DIV_ITER;
        end
        DIV_ITER: begin
          rem   <= diff[32] ? rem_sh[31:0] : diff[31:0];
          quo   <= {quo[30:0], ~diff[32]};
          cnt   <= cnt + 5'd1;
          if (iter_last) phase <= DIV_FIX;
        end
        DIV_FIX: phase <= IDLE;
        default: phase <= IDLE;
      endcase
    end
  end

  assign iter_last = (phase == DIV_ITER) && (cnt == 5'(DIV_ITERS - 1));
  assign done      = (phase == DIV_FIX);
  assign div_zero  = dz;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/mdu_57.sv
// mdu_57 -- MIPS-style HI/LO multiply/divide unit.
//   clk, reset_n      : clock, async active-low reset
//   flush             : abort in-progress op (only with MDU_57_FLUSH_EN)
//   start, op         : request strobe and operation (see mdu_57_pkg)
//   rs_d, rt_d        : operands A / B
//   busy              : operation in progress
//   hi, lo            : architectural HI/LO registers
// Parameter MULT_CYCLES (1..16): busy cycles for mult/multu.
// Define MDU_57_FLUSH_EN to add the flush input.
module mdu_57
  import mdu_57_pkg::*;
#(
  parameter int MULT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef MDU_57_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_d,
  input  logic [31:0] rt_d,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state;
  logic [63:0] prod;
  logic [4:0]  mcnt;
  logic        flush_i;

`ifdef MDU_57_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  logic is_mul, is_div, div_start;
  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign div_start = (state == IDLE) && start && !flush_i && is_div;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the 64x64 product
  // are then the exact 32x32 product for either signedness.
  logic [63:0] a_ext, b_ext, prod_next;
  assign a_ext     = {{32{(op == OP_MULT) && rs_d[31]}}, rs_d};
  assign b_ext     = {{32{(op == OP_MULT) && rt_d[31]}}, rt_d};
  assign prod_next = a_ext * b_ext;

  logic        div_last, div_done, div_zero;
  logic [31:0] div_quo, div_rem;

  mdu_57_div u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .abort     (flush_i),
    .is_signed (op == OP_DIV),
    .dividend  (rs_d),
    .divisor   (rt_d),
    .iter_last (div_last),
    .done      (div_done),
    .div_zero  (div_zero),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      prod  <= '0;
      mcnt  <= '0;
    end else if (flush_i) begin
      // Flush wins over completion and over a same-cycle start.
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (is_mul) begin
            prod  <= prod_next;
            mcnt  <= 5'(MULT_CYCLES);
            state <= MUL;
            busy  <= 1'b1;
          end else if (is_div) begin
            state <= DIV_SETUP;
            busy  <= 1'b1;
          end else if (op == OP_MTHI) begin
            hi <= rs_d;
          end else if (op == OP_MTLO) begin
            lo <= rs_d;
          end
        end
        MUL: begin
          if (mcnt == 5'd1) begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            mcnt <= mcnt - 5'd1;
          end
        end
        DIV_SETUP: state <= DIV_ITER;
        DIV_ITER:  if (div_last) state <= DIV_FIX;
        DIV_FIX: begin
          // Divide by zero runs the full sequence but commits nothing.
          if (div_done && !div_zero) begin
            hi <= div_rem;
            lo <= div_quo;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_57.sv
// tb_mdu_57 -- self-checking bench for mdu_57: directed cases with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural HI/LO model. Define MDU_57_FLUSH_EN to exercise flush.
module tb_mdu_57;
  import mdu_57_pkg::*;

  localparam int MC = 5;
`ifdef MDU_57_FLUSH_EN
  localparam bit HAS_FLUSH = 1'b1;
`else
  localparam bit HAS_FLUSH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, flush, start;
  logic [2:0]  op;
  logic [31:0] rs_d, rt_d, hi, lo;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mdu_57 #(.MULT_CYCLES(MC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef MDU_57_FLUSH_EN
    .flush   (flush),
`endif
    .start   (start),
    .op      (op),
    .rs_d    (rs_d),
    .rt_d    (rt_d),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cnt;      // busy cycles still to run
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;       // result to commit on completion

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  function automatic logic [63:0] umul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y;
    x = {32'b0, a};
    y = {32'b0, b};
    return x * y;
  endfunction

  // returns {remainder, quotient}; caller guarantees b != 0
  function automatic logic [63:0] divmod(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint x, y, q, r;
    x = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= 0; m_hi <= '0; m_lo <= '0; p_wr <= 1'b0;
    end else if (HAS_FLUSH && flush) begin
      m_cnt <= 0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && p_wr) begin
        m_hi <= p_hi; m_lo <= p_lo;
      end
    end else if (start) begin
      case (op)
        OP_MULT:  begin {p_hi, p_lo} <= smul(rs_d, rt_d); p_wr <= 1'b1; m_cnt <= MC; end
        OP_MULTU: begin {p_hi, p_lo} <= umul(rs_d, rt_d); p_wr <= 1'b1; m_cnt <= MC; end
        OP_DIV, OP_DIVU: begin
          p_wr  <= (rt_d != 0);
          if (rt_d != 0) {p_hi, p_lo} <= divmod(rs_d, rt_d, op == OP_DIV);
          m_cnt <= DIV_CYCLES;
        end
        OP_MTHI: m_hi <= rs_d;
        OP_MTLO: m_lo <= rs_d;
        default: ;
      endcase
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_cnt != 0});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1 while idle; returns at posedge+1 after the accepting edge
  // with the operands scrambled so late changes are exercised.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_d = a; rt_d = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); rs_d = $urandom; rt_d = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic chk_hl(input string nm, input logic [31:0] eh, input logic [31:0] el);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_model_hi"}, m_hi, eh);
    chk({nm, "_model_lo"}, m_lo, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    reset_n = 1'b0; flush = 1'b0; start = 1'b0; op = '0; rs_d = '0; rt_d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(posedge clk); #1;

    issue(OP_MULT, 32'hFFFF_FFFF, 32'h2);
    wait_idle(n); chk("mult_busy", 32'(n), 32'd5);
    chk_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    wait_idle(n); chk("multu_busy", 32'(n), 32'd5);
    chk_hl("multu", 32'h1, 32'hFFFF_FFFE);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_idle(n); chk("div_busy", 32'(n), 32'd34);
    chk_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle(n); chk("divu_busy", 32'(n), 32'd34);
    chk_hl("divu", 32'd2, 32'd14);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk_hl("div_ovf", 32'h0, 32'h8000_0000);

    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    wait_idle(n); chk("mthi_busy", 32'(n), 32'd0);
    issue(OP_DIVU, 32'h55, 32'h0);
    wait_idle(n); chk("div0_busy", 32'(n), 32'd34);
    chk_hl("div0", 32'h1234_5678, 32'h8000_0000);

    // start while busy must be ignored; original operands deliver
    issue(OP_MULT, 32'h0001_0000, 32'h0001_0000);
    start = 1'b1; op = OP_MTHI; rs_d = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    op = OP_DIVU; rt_d = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(n); chk("ignore_busy", 32'(n), 32'(MC - 2));
    chk_hl("ignore", 32'h1, 32'h0);

`ifdef MDU_57_FLUSH_EN
    issue(OP_MTHI, 32'hA5A5_A5A5, 32'h0);
    issue(OP_MTLO, 32'h5A5A_5A5A, 32'h0);
    issue(OP_MULT, 32'd3, 32'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1; start = 1'b1; op = OP_MTLO; rs_d = 32'h0;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk_hl("flush", 32'hA5A5_A5A5, 32'h5A5A_5A5A);
`endif

    // reset in the middle of a divide
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle(n); chk("postrst_busy", 32'(n), 32'd34);
    chk_hl("postrst", 32'd2, 32'd14);

    // randomized traffic, including starts while busy and reserved ops
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom % 3) == 0;
      op    = 3'($urandom);
      rs_d  = pick();
      rt_d  = pick();
      flush = HAS_FLUSH && (($urandom % 40) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0;
    wait_idle(n);
    chk("final_idle", {31'b0, busy}, 32'd0);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
